// File: rtl/mac_learn_table.sv
// MAC learning/forwarding table: DA lookup then SA learn per descriptor, periodic aging sweep.
// Optional XOR-fold index hashing is enabled by defining MAC_LEARN_TABLE_HASH_EN.
module mac_learn_table #(
    parameter int pTIME        = 300,
    parameter int pCLK_PER_SEC = 125_000_000,
    parameter int pNUM_PORTS   = 4,
    parameter int pADDR_WIDTH  = 14,
    parameter int pIDX_WIDTH   = 10
) (
    input  logic                          iclk,
    input  logic                          irst_n,
    input  logic                          ivalid,
    output logic                          oready,
    input  logic [$clog2(pNUM_PORTS)-1:0] ipnum,
    input  logic [pADDR_WIDTH-1:0]        isa,
    input  logic [pADDR_WIDTH-1:0]        ida,
    output logic                          ovalid,
    output logic                          ohit,
    output logic [$clog2(pNUM_PORTS)-1:0] opnum,
    output logic [pNUM_PORTS-1:0]         oport_mask,
    output logic                          ocollide
);

    localparam int NP    = pNUM_PORTS;
    localparam int PW    = $clog2(pNUM_PORTS);
    localparam int AW    = pADDR_WIDTH;
    localparam int IW    = pIDX_WIDTH;
    localparam int DEPTH = 2 ** pIDX_WIDTH;
    localparam int AGW   = $clog2(pTIME + 1);
    localparam int TW    = $clog2(pCLK_PER_SEC);

    localparam logic [IW-1:0]  IDX_LAST  = {IW{1'b1}};
    localparam logic [TW-1:0]  TICK_LAST = TW'(pCLK_PER_SEC - 1);
    localparam logic [AGW-1:0] AGE_INIT  = AGW'(pTIME);

    typedef struct packed {
        logic           valid;
        logic [AW-1:0]  tag;
        logic [PW-1:0]  port;
        logic [AGW-1:0] age;
    } entry_t;

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_LOOK_DA,
        S_LEARN_RD,
        S_LEARN_WR,
        S_AGE_RD,
        S_AGE_WR
    } state_t;

    state_t         r_state;
    state_t         w_next;
    entry_t         r_mem [DEPTH];
    entry_t         r_rd;
    entry_t         w_wdata;
    entry_t         w_learn;
    entry_t         w_aged;
    logic [IW-1:0]  w_addr;
    logic           w_we;
    logic [IW-1:0]  r_idx;
    logic [TW-1:0]  r_tick;
    logic           r_pending;
    logic [PW-1:0]  r_pnum;
    logic [AW-1:0]  r_sa;
    logic [AW-1:0]  r_da;
    logic [IW-1:0]  w_sa_idx;
    logic [IW-1:0]  w_da_idx;
    logic           w_accept;
    logic           w_hit;
    logic [NP-1:0]  w_mask;
    logic           w_tick_wrap;
    logic           w_sweep_done;

`ifdef MAC_LEARN_TABLE_HASH_EN
    localparam int NS   = (AW + IW - 1) / IW;
    localparam int PADW = NS * IW;

    logic [PADW-1:0] w_sa_pad;
    logic [PADW-1:0] w_da_pad;

    always_comb begin
        w_sa_pad = PADW'(r_sa);
        w_da_pad = PADW'(r_da);
        w_sa_idx = '0;
        w_da_idx = '0;
        for (int s = 0; s < NS; s++) begin
            w_sa_idx = w_sa_idx ^ w_sa_pad[s*IW +: IW];
            w_da_idx = w_da_idx ^ w_da_pad[s*IW +: IW];
        end
    end
`else
    assign w_sa_idx = r_sa[IW-1:0];
    assign w_da_idx = r_da[IW-1:0];
`endif

    assign w_accept     = (r_state == S_IDLE) && !r_pending && ivalid;
    assign w_tick_wrap  = (r_tick == TICK_LAST);
    assign w_sweep_done = (r_state == S_AGE_WR) && (r_idx == IDX_LAST);

    always_comb begin
        w_hit  = r_rd.valid && (r_rd.tag == r_da);
        w_mask = ~(NP'(1) << r_pnum);
        if (w_hit) begin
            w_mask = (r_rd.port == r_pnum) ? '0 : (NP'(1) << r_rd.port);
        end
    end

    always_comb begin
        w_learn       = '0;
        w_learn.valid = 1'b1;
        w_learn.tag   = r_sa;
        w_learn.port  = r_pnum;
        w_learn.age   = AGE_INIT;
        w_aged        = r_rd;
        if (r_rd.valid) begin
            if (r_rd.age <= AGW'(1)) begin
                w_aged.valid = 1'b0;
                w_aged.age   = '0;
            end else begin
                w_aged.age = r_rd.age - AGW'(1);
            end
        end
    end

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            r_state <= S_INIT;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_addr  = '0;
        w_we    = 1'b0;
        w_wdata = '0;
        oready  = 1'b0;
        unique case (r_state)
            S_INIT: begin
                w_addr = r_idx;
                w_we   = 1'b1;
                if (r_idx == IDX_LAST) begin
                    w_next = S_IDLE;
                end
            end
            S_IDLE: begin
                if (r_pending) begin
                    w_next = S_AGE_RD;
                end else begin
                    oready = 1'b1;
                    if (ivalid) begin
                        w_next = S_LOOK_DA;
                    end
                end
            end
            S_LOOK_DA: begin
                w_addr = w_da_idx;
                w_next = S_LEARN_RD;
            end
            S_LEARN_RD: begin
                w_addr = w_sa_idx;
                w_next = S_LEARN_WR;
            end
            S_LEARN_WR: begin
                w_addr  = w_sa_idx;
                w_we    = 1'b1;
                w_wdata = w_learn;
                w_next  = S_IDLE;
            end
            S_AGE_RD: begin
                w_addr = r_idx;
                w_next = S_AGE_WR;
            end
            S_AGE_WR: begin
                w_addr  = r_idx;
                w_we    = 1'b1;
                w_wdata = w_aged;
                w_next  = (r_idx == IDX_LAST) ? S_IDLE : S_AGE_RD;
            end
            default: begin
                w_next = S_INIT;
            end
        endcase
    end

    // Single-port table: synchronous read, old data returned on a write cycle.
    always_ff @(posedge iclk) begin
        if (w_we) begin
            r_mem[w_addr] <= w_wdata;
        end
        r_rd <= r_mem[w_addr];
    end

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            r_idx      <= '0;
            r_tick     <= '0;
            r_pending  <= 1'b0;
            r_pnum     <= '0;
            r_sa       <= '0;
            r_da       <= '0;
            ovalid     <= 1'b0;
            ohit       <= 1'b0;
            opnum      <= '0;
            oport_mask <= '0;
            ocollide   <= 1'b0;
        end else begin
            r_tick <= w_tick_wrap ? '0 : r_tick + TW'(1);
            if (w_tick_wrap) begin
                r_pending <= 1'b1;
            end else if (w_sweep_done) begin
                r_pending <= 1'b0;
            end
            if (r_state == S_INIT || r_state == S_AGE_WR) begin
                r_idx <= r_idx + IW'(1);
            end
            if (w_accept) begin
                r_pnum <= ipnum;
                r_sa   <= isa;
                r_da   <= ida;
            end
            ovalid     <= (r_state == S_LEARN_RD);
            ohit       <= (r_state == S_LEARN_RD) && w_hit;
            opnum      <= ((r_state == S_LEARN_RD) && w_hit) ? r_rd.port : '0;
            oport_mask <= (r_state == S_LEARN_RD) ? w_mask : '0;
            ocollide   <= (r_state == S_LEARN_WR) && r_rd.valid
                          && (r_rd.tag != r_sa);
        end
    end

endmodule

// File: tb/tb_mac_learn_table.sv
// Self-checking bench for mac_learn_table with a table-level reference model.
// Parameters: pCLK_PER_SEC=100, pTIME=3, pIDX_WIDTH=4, hashing disabled.
module tb_mac_learn_table;

    logic        iclk = 1'b0;
    logic        irst_n = 1'b0;
    logic        ivalid = 1'b0;
    logic        oready;
    logic [1:0]  ipnum = '0;
    logic [13:0] isa = '0;
    logic [13:0] ida = '0;
    logic        ovalid;
    logic        ohit;
    logic [1:0]  opnum;
    logic [3:0]  oport_mask;
    logic        ocollide;

    int n_checks = 0;
    int n_pass = 0;
    int cyc;

    // Reference table, indexed by the low 4 key bits.
    bit m_valid [16];
    int m_tag   [16];
    int m_port  [16];
    int m_age   [16];
    int next_sweep;

    mac_learn_table #(
        .pTIME(3),
        .pCLK_PER_SEC(100),
        .pNUM_PORTS(4),
        .pADDR_WIDTH(14),
        .pIDX_WIDTH(4)
    ) dut (
        .iclk(iclk),
        .irst_n(irst_n),
        .ivalid(ivalid),
        .oready(oready),
        .ipnum(ipnum),
        .isa(isa),
        .ida(ida),
        .ovalid(ovalid),
        .ohit(ohit),
        .opnum(opnum),
        .oport_mask(oport_mask),
        .ocollide(ocollide)
    );

    always #5 iclk = ~iclk;

    always @(posedge iclk or negedge irst_n) begin
        if (!irst_n) cyc <= 0;
        else cyc <= cyc + 1;
    end

    task automatic m_clear();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 0;
            m_tag[i] = 0;
            m_port[i] = 0;
            m_age[i] = 0;
        end
        next_sweep = 100;
    endtask

    // Sweeps fire once per 100 cycles; one due at the accept edge runs after the request.
    task automatic m_req(input int p, input int sa, input int da, input int e,
                         output logic eh, output logic [1:0] epn,
                         output logic [3:0] emk, output logic ecol);
        int di;
        int si;
        logic [3:0] one;
        while (next_sweep < e) begin
            for (int i = 0; i < 16; i++) begin
                if (m_valid[i]) begin
                    m_age[i] = m_age[i] - 1;
                    if (m_age[i] == 0) m_valid[i] = 0;
                end
            end
            next_sweep += 100;
        end
        di = da % 16;
        eh = m_valid[di] && (m_tag[di] == da);
        epn = eh ? 2'(m_port[di]) : 2'd0;
        if (eh) begin
            one = 4'b0001 << m_port[di];
            emk = (m_port[di] == p) ? 4'b0000 : one;
        end else begin
            one = 4'b0001 << p;
            emk = ~one;
        end
        si = sa % 16;
        ecol = m_valid[si] && (m_tag[si] != sa);
        m_valid[si] = 1;
        m_tag[si] = sa;
        m_port[si] = p;
        m_age[si] = 3;
    endtask

    task automatic do_req(input logic [1:0] p, input logic [13:0] sa,
                          input logic [13:0] da,
                          output logic h, output logic [1:0] pn,
                          output logic [3:0] mk, output logic col,
                          output logic tok, output int acc);
        int w;
        @(negedge iclk);
        ipnum = p;
        isa = sa;
        ida = da;
        ivalid = 1'b1;
        w = 0;
        tok = 1'b1;
        h = 1'b0;
        pn = '0;
        mk = '0;
        col = 1'b0;
        acc = 0;
        while (!oready && w < 300) begin
            @(negedge iclk);
            w++;
        end
        if (!oready) begin
            ivalid = 1'b0;
            tok = 1'b0;
            return;
        end
        acc = cyc + 1;
        @(negedge iclk);
        ivalid = 1'b0;
        if (oready || ovalid || ocollide) tok = 1'b0;
        if (ohit || opnum != 0 || oport_mask != 0) tok = 1'b0;
        @(negedge iclk);
        if (ovalid || ocollide) tok = 1'b0;
        if (ohit || opnum != 0 || oport_mask != 0) tok = 1'b0;
        @(negedge iclk);
        if (!ovalid || ocollide) tok = 1'b0;
        h = ohit;
        pn = opnum;
        mk = oport_mask;
        @(negedge iclk);
        if (ovalid) tok = 1'b0;
        if (ohit || opnum != 0 || oport_mask != 0) tok = 1'b0;
        col = ocollide;
        @(negedge iclk);
        if (ocollide) tok = 1'b0;
    endtask

    task automatic test_reset();
        logic bad;
        irst_n = 1'b0;
        ivalid = 1'b0;
        repeat (3) @(negedge iclk);
        n_checks++;
        if (oready !== 1'b0 || ovalid !== 1'b0 || ohit !== 1'b0 || opnum !== 2'd0
            || oport_mask !== 4'd0 || ocollide !== 1'b0)
            $display("FAIL reset_outputs got rdy=%b v=%b h=%b pn=%0d mk=%b col=%b want all 0",
                     oready, ovalid, ohit, opnum, oport_mask, ocollide);
        else n_pass++;
        irst_n = 1'b1;
        m_clear();
        bad = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge iclk);
            n_checks++;
            if (oready !== (k == 16))
                $display("FAIL init_ready edge %0d got %b want %b", k, oready, k == 16);
            else n_pass++;
            if (ovalid || ohit || opnum != 0 || oport_mask != 0 || ocollide) bad = 1'b1;
        end
        n_checks++;
        if (bad) $display("FAIL init_outputs got nonzero want 0");
        else n_pass++;
    endtask

    task automatic test_learn_forward();
        logic h, col, tok, eh, ecol;
        logic [1:0] pn, epn;
        logic [3:0] mk, emk;
        int acc;
        do_req(2'd1, 14'h0011, 14'h0022, h, pn, mk, col, tok, acc);
        m_req(1, 'h11, 'h22, acc, eh, epn, emk, ecol);
        n_checks++;
        if (!tok || h !== eh || mk !== emk || h !== 1'b0 || mk !== 4'b1101)
            $display("FAIL fwd_miss tok=%b got h=%b mk=%b want h=%b mk=%b",
                     tok, h, mk, eh, emk);
        else n_pass++;
        do_req(2'd2, 14'h0022, 14'h0011, h, pn, mk, col, tok, acc);
        m_req(2, 'h22, 'h11, acc, eh, epn, emk, ecol);
        n_checks++;
        if (!tok || h !== eh || pn !== epn || mk !== emk || pn !== 2'd1 || mk !== 4'b0010)
            $display("FAIL fwd_hit tok=%b got h=%b pn=%0d mk=%b want h=%b pn=%0d mk=%b",
                     tok, h, pn, mk, eh, epn, emk);
        else n_pass++;
    endtask

    task automatic test_filter();
        logic h, col, tok, eh, ecol;
        logic [1:0] pn, epn;
        logic [3:0] mk, emk;
        int acc;
        do_req(2'd1, 14'h0031, 14'h0011, h, pn, mk, col, tok, acc);
        m_req(1, 'h31, 'h11, acc, eh, epn, emk, ecol);
        n_checks++;
        if (!tok || h !== eh || mk !== emk || h !== 1'b1 || mk !== 4'b0000)
            $display("FAIL filter tok=%b got h=%b mk=%b want h=%b mk=%b",
                     tok, h, mk, eh, emk);
        else n_pass++;
    endtask

    task automatic test_collision();
        logic h, col, tok, eh, ecol;
        logic [1:0] pn, epn;
        logic [3:0] mk, emk;
        int acc;
        do_req(2'd3, 14'h0013, 14'h0100, h, pn, mk, col, tok, acc);
        m_req(3, 'h13, 'h100, acc, eh, epn, emk, ecol);
        do_req(2'd0, 14'h0023, 14'h0101, h, pn, mk, col, tok, acc);
        m_req(0, 'h23, 'h101, acc, eh, epn, emk, ecol);
        n_checks++;
        if (!tok || col !== ecol || col !== 1'b1)
            $display("FAIL collide_pulse tok=%b got %b want %b", tok, col, ecol);
        else n_pass++;
        do_req(2'd1, 14'h0102, 14'h0013, h, pn, mk, col, tok, acc);
        m_req(1, 'h102, 'h13, acc, eh, epn, emk, ecol);
        n_checks++;
        if (!tok || h !== eh || h !== 1'b0 || mk !== emk || col !== ecol)
            $display("FAIL collide_evicted tok=%b got h=%b mk=%b col=%b want h=%b mk=%b col=%b",
                     tok, h, mk, col, eh, emk, ecol);
        else n_pass++;
        do_req(2'd1, 14'h0103, 14'h0023, h, pn, mk, col, tok, acc);
        m_req(1, 'h103, 'h23, acc, eh, epn, emk, ecol);
        n_checks++;
        if (!tok || h !== eh || pn !== epn || mk !== emk || h !== 1'b1 || pn !== 2'd0)
            $display("FAIL collide_new tok=%b got h=%b pn=%0d mk=%b want h=%b pn=%0d mk=%b",
                     tok, h, pn, mk, eh, epn, emk);
        else n_pass++;
    endtask

    task automatic test_aging();
        logic h, col, tok, eh, ecol;
        logic [1:0] pn, epn;
        logic [3:0] mk, emk;
        int acc;
        do_req(2'd1, 14'h0011, 14'h0200, h, pn, mk, col, tok, acc);
        m_req(1, 'h11, 'h200, acc, eh, epn, emk, ecol);
        repeat (400) @(negedge iclk);
        do_req(2'd2, 14'h0210, 14'h0011, h, pn, mk, col, tok, acc);
        m_req(2, 'h210, 'h11, acc, eh, epn, emk, ecol);
        n_checks++;
        if (!tok || h !== eh || h !== 1'b0 || mk !== emk)
            $display("FAIL aged_out tok=%b got h=%b mk=%b want h=%b mk=%b",
                     tok, h, mk, eh, emk);
        else n_pass++;
        do_req(2'd3, 14'h0055, 14'h0300, h, pn, mk, col, tok, acc);
        m_req(3, 'h55, 'h300, acc, eh, epn, emk, ecol);
        for (int r = 0; r < 4; r++) begin
            repeat (150) @(negedge iclk);
            do_req(2'd3, 14'h0055, 14'h0300, h, pn, mk, col, tok, acc);
            m_req(3, 'h55, 'h300, acc, eh, epn, emk, ecol);
        end
        do_req(2'd0, 14'h0301, 14'h0055, h, pn, mk, col, tok, acc);
        m_req(0, 'h301, 'h55, acc, eh, epn, emk, ecol);
        n_checks++;
        if (!tok || h !== eh || h !== 1'b1 || pn !== 2'd3 || mk !== 4'b1000)
            $display("FAIL refresh_hit tok=%b got h=%b pn=%0d mk=%b want h=%b pn=%0d mk=%b",
                     tok, h, pn, mk, eh, epn, emk);
        else n_pass++;
    endtask

    task automatic test_sweep_wait();
        logic h, col, tok, eh, ecol;
        logic [1:0] pn, epn;
        logic [3:0] mk, emk;
        int acc;
        int start;
        int w;
        w = 0;
        @(negedge iclk);
        while ((cyc % 100) != 1 && w < 300) begin
            @(negedge iclk);
            w++;
        end
        start = cyc;
        n_checks++;
        if ((cyc % 100) != 1 || oready !== 1'b0)
            $display("FAIL sweep_busy cyc=%0d got rdy=%b want 0", cyc, oready);
        else n_pass++;
        do_req(2'd2, 14'h0077, 14'h0055, h, pn, mk, col, tok, acc);
        m_req(2, 'h77, 'h55, acc, eh, epn, emk, ecol);
        n_checks++;
        if (!tok || acc != start + 33 || h !== eh || pn !== epn || mk !== emk)
            $display("FAIL sweep_wait accept edge got %0d want %0d h=%b/%b mk=%b/%b",
                     acc, start + 33, h, eh, mk, emk);
        else n_pass++;
    endtask

    task automatic test_random();
        logic h, col, tok, eh, ecol;
        logic [1:0] pn, epn;
        logic [3:0] mk, emk;
        logic [1:0] p;
        logic [13:0] sa, da;
        int acc;
        for (int n = 0; n < 40; n++) begin
            p = 2'($urandom_range(0, 3));
            sa = 14'($urandom_range(0, 15) + 16 * $urandom_range(0, 2));
            da = 14'($urandom_range(0, 15) + 16 * $urandom_range(0, 2));
            if ($urandom_range(0, 3) == 0) sa = sa | 14'h2000;
            repeat ($urandom_range(0, 40)) @(negedge iclk);
            do_req(p, sa, da, h, pn, mk, col, tok, acc);
            m_req(int'(p), int'(sa), int'(da), acc, eh, epn, emk, ecol);
            n_checks++;
            if (!tok || h !== eh || pn !== epn || mk !== emk || col !== ecol)
                $display("FAIL rand%0d sa=%h da=%h p=%0d tok=%b got %b/%0d/%b/%b want %b/%0d/%b/%b",
                         n, sa, da, p, tok, h, pn, mk, col, eh, epn, emk, ecol);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        logic h, col, tok, eh, ecol;
        logic [1:0] pn, epn;
        logic [3:0] mk, emk;
        logic bad;
        int acc;
        int w;
        do_req(2'd1, 14'h0044, 14'h0300, h, pn, mk, col, tok, acc);
        m_req(1, 'h44, 'h300, acc, eh, epn, emk, ecol);
        @(negedge iclk);
        ipnum = 2'd2;
        isa = 14'h0305;
        ida = 14'h0044;
        ivalid = 1'b1;
        w = 0;
        while (!oready && w < 300) begin
            @(negedge iclk);
            w++;
        end
        @(posedge iclk);
        @(posedge iclk);
        #1;
        irst_n = 1'b0;
        ivalid = 1'b0;
        bad = (w >= 300);
        repeat (4) begin
            @(negedge iclk);
            if (ovalid || ocollide || oready) bad = 1'b1;
        end
        irst_n = 1'b1;
        m_clear();
        for (int k = 1; k <= 16; k++) begin
            @(negedge iclk);
            if (ovalid || ocollide) bad = 1'b1;
            if (oready !== (k == 16)) bad = 1'b1;
        end
        n_checks++;
        if (bad) $display("FAIL reset_mid_abort got response or bad init want none");
        else n_pass++;
        do_req(2'd0, 14'h0306, 14'h0044, h, pn, mk, col, tok, acc);
        m_req(0, 'h306, 'h44, acc, eh, epn, emk, ecol);
        n_checks++;
        if (!tok || h !== eh || h !== 1'b0 || mk !== emk || mk !== 4'b1110)
            $display("FAIL reset_mid_miss tok=%b got h=%b mk=%b want h=%b mk=%b",
                     tok, h, mk, eh, emk);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_learn_forward();
        test_filter();
        test_collision();
        test_aging();
        test_sweep_wait();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
